// File: rtl/rx_iq_pkg.sv
// Shared types and constants for the receive-side IQ elastic buffer.
// One stored sample set is {rx1_i, rx1_q, rx2_i, rx2_q}, most significant first.
package rx_iq_pkg;

    localparam int IQ_W          = 24;
    localparam int IQ_WORD_W     = 4 * IQ_W;
    localparam int DEFAULT_DEPTH = 32;

    // Bit offsets of each component inside the packed storage word.
    localparam int RX2_Q_OFF = 0;
    localparam int RX2_I_OFF = IQ_W;
    localparam int RX1_Q_OFF = 2 * IQ_W;
    localparam int RX1_I_OFF = 3 * IQ_W;

    typedef struct packed {
        logic [IQ_W-1:0] rx1_i;
        logic [IQ_W-1:0] rx1_q;
        logic [IQ_W-1:0] rx2_i;
        logic [IQ_W-1:0] rx2_q;
    } iq_set_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/rx_iq_buffer_fifo_ram.sv
// Simple dual-port sample-set memory: synchronous write, registered read.
// A write to the address being read is forwarded so a freshly written head is visible next cycle.
module rx_iq_fifo_ram
    import rx_iq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        wr_addr,
    input  logic [IQ_WORD_W-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [IQ_WORD_W-1:0] rd_data
);

    logic [IQ_WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (we && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_iq_buffer.sv
// RX IQ elastic buffer: captures RX1+RX2 sample sets from the decimators and presents
// the oldest one first-word-fall-through to the STM32 bus, popping on read-clock rising edges.
module rx_iq_buffer
    import rx_iq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic [IQ_W-1:0] rx1_i_in,
    input  logic [IQ_W-1:0] rx1_q_in,
    input  logic [IQ_W-1:0] rx2_i_in,
    input  logic [IQ_W-1:0] rx2_q_in,
    input  logic            rx_valid,
    input  logic            IQ_RX_READ_REQ,
    input  logic            IQ_RX_READ_CLK,
    input  logic            overrun_clr,
    output logic [IQ_W-1:0] RX1_I,
    output logic [IQ_W-1:0] RX1_Q,
    output logic [IQ_W-1:0] RX2_I,
    output logic [IQ_W-1:0] RX2_Q,
    output logic            iq_overrun,
    output logic            iq_underrun,
    output logic            empty,
    output logic [AW:0]     level,
    output logic            fsm_state
);

    // Handshake: rx_valid is a one-cycle push with no back-pressure (a full buffer drops the
    // set and raises iq_overrun); a pop is a qualified rising edge of IQ_RX_READ_CLK while
    // IQ_RX_READ_REQ is high, and the bus latches the head presented on that same edge.

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        rd_addr;
    logic [AW:0]          level_q;
    logic [AW:0]          level_d;
    logic                 read_clk_d;
    logic                 ovr_q;
    logic                 udr_q;
    logic                 pop;
    logic                 pop_eff;
    logic                 wr_eff;
    logic                 is_empty;
    logic                 is_full;
    logic                 overrun_ev;
    logic                 underrun_ev;
    logic [IQ_WORD_W-1:0] head_word;
    iq_set_t              wr_set;
    state_t               state_q;
    state_t               state_d;

    assign pop      = IQ_RX_READ_CLK & ~read_clk_d & IQ_RX_READ_REQ;
    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == (AW+1)'(DEPTH));
    assign pop_eff  = pop & ~is_empty;
    // A pop on a full buffer frees the head slot in time for the concurrent write.
    assign wr_eff   = rx_valid & (~is_full | pop_eff);

    assign overrun_ev  = rx_valid & is_full & ~pop;
    assign underrun_ev = pop & is_empty;

    always_comb begin
        level_d = level_q;
        case ({wr_eff, pop_eff})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Read lookahead: fetch the next head on a pop so FWFT data is ready the following cycle.
    assign rd_addr = pop_eff ? (rd_ptr + AW'(1)) : rd_ptr;

    assign wr_set.rx1_i = rx1_i_in;
    assign wr_set.rx1_q = rx1_q_in;
    assign wr_set.rx2_i = rx2_i_in;
    assign wr_set.rx2_q = rx2_q_in;

    rx_iq_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk_in),
        .we      (wr_eff & ~reset_in),
        .wr_addr (wr_ptr),
        .wr_data (wr_set),
        .rd_addr (rd_addr),
        .rd_data (head_word)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            read_clk_d <= 1'b0;
            ovr_q      <= 1'b0;
            udr_q      <= 1'b0;
        end else begin
            read_clk_d <= IQ_RX_READ_CLK;
            if (wr_eff) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level_q <= level_d;
            // A new event beats a clear in the same cycle.
            if (overrun_ev) begin
                ovr_q <= 1'b1;
            end else if (overrun_clr) begin
                ovr_q <= 1'b0;
            end
            if (underrun_ev) begin
                udr_q <= 1'b1;
            end else if (overrun_clr) begin
                udr_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (wr_eff) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pop_eff && (level_q == (AW+1)'(1)) && !wr_eff) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        RX1_I = '0;
        RX1_Q = '0;
        RX2_I = '0;
        RX2_Q = '0;
        if (!is_empty) begin
            RX1_I = head_word[RX1_I_OFF +: IQ_W];
            RX1_Q = head_word[RX1_Q_OFF +: IQ_W];
            RX2_I = head_word[RX2_I_OFF +: IQ_W];
            RX2_Q = head_word[RX2_Q_OFF +: IQ_W];
        end
    end

    assign iq_overrun  = ovr_q;
    assign iq_underrun = udr_q;
    assign empty       = (state_q == ST_EMPTY);
    assign level       = level_q;
    assign fsm_state   = (state_q == ST_HOLD);

endmodule

// File: tb/tb_rx_iq_buffer.sv
// Directed bench for rx_iq_buffer: a negedge monitor checks every set latched by a pop
// against an expected queue; drivers run one cycle at a time and check status 1ns after the edge.
module tb_rx_iq_buffer;
    import rx_iq_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            reset_in;
    logic [IQ_W-1:0] rx1_i_in, rx1_q_in, rx2_i_in, rx2_q_in;
    logic            rx_valid;
    logic            IQ_RX_READ_REQ;
    logic            IQ_RX_READ_CLK;
    logic            overrun_clr;
    logic [IQ_W-1:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
    logic            iq_overrun, iq_underrun, empty, fsm_state;
    logic [AW:0]     level;

    logic [IQ_WORD_W-1:0] exp_q[$];
    int                   n_vec = 0;
    int                   n_err = 0;
    logic                 rclk_seen = 1'b0;

    rx_iq_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_in         (clk),
        .reset_in       (reset_in),
        .rx1_i_in       (rx1_i_in),
        .rx1_q_in       (rx1_q_in),
        .rx2_i_in       (rx2_i_in),
        .rx2_q_in       (rx2_q_in),
        .rx_valid       (rx_valid),
        .IQ_RX_READ_REQ (IQ_RX_READ_REQ),
        .IQ_RX_READ_CLK (IQ_RX_READ_CLK),
        .overrun_clr    (overrun_clr),
        .RX1_I          (RX1_I),
        .RX1_Q          (RX1_Q),
        .RX2_I          (RX2_I),
        .RX2_Q          (RX2_Q),
        .iq_overrun     (iq_overrun),
        .iq_underrun    (iq_underrun),
        .empty          (empty),
        .level          (level),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic cmp(input string name, input logic [IQ_WORD_W-1:0] act,
                       input logic [IQ_WORD_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [IQ_WORD_W-1:0] outs();
        return {RX1_I, RX1_Q, RX2_I, RX2_Q};
    endfunction

    function automatic logic [IQ_WORD_W-1:0] mk(input int k);
        return {24'hA00000 + 24'(k), 24'h5A0000 - 24'(k), 24'hFF0000 | 24'(k), 24'h000100 + 24'(k)};
    endfunction

    task automatic check_status(input string name, input int exp_level, input logic exp_empty,
                                input logic exp_ovr, input logic exp_udr);
        cmp({name, "_level"}, IQ_WORD_W'(level), IQ_WORD_W'(exp_level));
        cmp({name, "_empty"}, IQ_WORD_W'(empty), IQ_WORD_W'(exp_empty));
        cmp({name, "_overrun"}, IQ_WORD_W'(iq_overrun), IQ_WORD_W'(exp_ovr));
        cmp({name, "_underrun"}, IQ_WORD_W'(iq_underrun), IQ_WORD_W'(exp_udr));
    endtask

    // ---------------- monitor ----------------
    // The bus latches the presented head at the edge following a negedge where a pop is pending.
    always @(negedge clk) begin
        if (reset_in) begin
            rclk_seen = 1'b0;
        end else begin
            if (IQ_RX_READ_CLK && !rclk_seen && IQ_RX_READ_REQ) begin
                if (exp_q.size() > 0) begin
                    cmp("pop_data", outs(), exp_q.pop_front());
                end else begin
                    cmp("pop_empty_out", outs(), '0);
                    cmp("pop_empty_flag", IQ_WORD_W'(empty), IQ_WORD_W'(1));
                end
            end
            rclk_seen = IQ_RX_READ_CLK;
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic v, input logic [IQ_WORD_W-1:0] w, input logic rc,
                         input logic clr, input logic store);
        rx_valid       = v;
        {rx1_i_in, rx1_q_in, rx2_i_in, rx2_q_in} = w;
        IQ_RX_READ_CLK = rc;
        overrun_clr    = clr;
        tick();
        if (v && store) exp_q.push_back(w);
        rx_valid    = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic write_set(input logic [IQ_WORD_W-1:0] w);
        cycle(1'b1, w, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pop_once();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        tick();
        tick();
        reset_in = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    logic [IQ_WORD_W-1:0] s1;
    logic [IQ_WORD_W-1:0] nw;

    initial begin
        reset_in = 1'b1;
        rx_valid = 1'b0;
        {rx1_i_in, rx1_q_in, rx2_i_in, rx2_q_in} = '0;
        IQ_RX_READ_REQ = 1'b1;
        IQ_RX_READ_CLK = 1'b0;
        overrun_clr    = 1'b0;
        do_reset();
        check_status("reset", 0, 1'b1, 1'b0, 1'b0);
        cmp("reset_out", outs(), '0);
        cmp("reset_state", IQ_WORD_W'(fsm_state), '0);

        // Single set into an empty buffer, sign extremes pass bit-exact.
        s1 = {24'h000123, 24'hFFFF00, 24'h7FFFFF, 24'h800000};
        write_set(s1);
        cmp("first_out", outs(), s1);
        check_status("first", 1, 1'b0, 1'b0, 1'b0);
        cmp("first_state", IQ_WORD_W'(fsm_state), IQ_WORD_W'(1));
        pop_once();
        check_status("first_drained", 0, 1'b1, 1'b0, 1'b0);
        cmp("first_drained_out", outs(), '0);

        // Three sets read back in order.
        write_set(mk(1));
        write_set(mk(2));
        write_set(mk(3));
        check_status("abc_loaded", 3, 1'b0, 1'b0, 1'b0);
        cmp("abc_head", outs(), mk(1));
        pop_once();
        pop_once();
        pop_once();
        check_status("abc_drained", 0, 1'b1, 1'b0, 1'b0);
        cmp("abc_drained_out", outs(), '0);

        // Read strobe without request does not pop.
        write_set(mk(4));
        IQ_RX_READ_REQ = 1'b0;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        IQ_RX_READ_REQ = 1'b1;
        check_status("no_req", 1, 1'b0, 1'b0, 1'b0);
        pop_once();

        // Read clock held high for five cycles pops exactly once.
        write_set(mk(5));
        write_set(mk(6));
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_status("held_clk", 1, 1'b0, 1'b0, 1'b0);
        cmp("held_clk_head", outs(), mk(6));
        pop_once();

        // Fill to DEPTH, then one extra write is dropped.
        for (int k = 0; k < DEPTH; k++) write_set(mk(100 + k));
        check_status("full", DEPTH, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(999), 1'b0, 1'b0, 1'b0);
        check_status("overrun", DEPTH, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_status("overrun_clr", DEPTH, 1'b0, 1'b0, 1'b0);

        // Write and pop together while full: accepted, level holds, new set comes out last.
        nw = mk(500);
        cycle(1'b1, nw, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_status("full_wr_pop", DEPTH, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < DEPTH; k++) pop_once();
        check_status("full_drained", 0, 1'b1, 1'b0, 1'b0);

        // Pop on empty buffer.
        pop_once();
        check_status("underrun", 0, 1'b1, 1'b0, 1'b1);
        cmp("underrun_out", outs(), '0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_status("underrun_clr", 0, 1'b1, 1'b0, 1'b0);

        // Pop and write together on empty: underrun, set still stored.
        nw = mk(600);
        cycle(1'b1, nw, 1'b1, 1'b0, 1'b1);
        check_status("empty_wr_pop", 1, 1'b0, 1'b0, 1'b1);
        cmp("empty_wr_pop_out", outs(), nw);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        pop_once();
        check_status("empty_wr_pop_drained", 0, 1'b1, 1'b0, 1'b0);

        // Clear and underrun event in the same cycle: event wins.
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_status("clr_vs_event", 0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Reset with level=10 and a concurrent write and pop.
        for (int k = 0; k < 10; k++) write_set(mk(700 + k));
        check_status("pre_reset", 10, 1'b0, 1'b0, 1'b0);
        reset_in = 1'b1;
        cycle(1'b1, mk(800), 1'b1, 1'b0, 1'b0);
        reset_in       = 1'b0;
        IQ_RX_READ_CLK = 1'b0;
        exp_q.delete();
        check_status("mid_reset", 0, 1'b1, 1'b0, 1'b0);
        cmp("mid_reset_out", outs(), '0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_status("post_reset", 0, 1'b1, 1'b0, 1'b0);

        cmp("queue_drained", IQ_WORD_W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_iq_buffer.md
Name: rx_iq_buffer

Overview:
- Receive-side IQ elastic buffer between the RX DDC outputs (CIC/FIR decimators for RX1 and RX2) and the STM32 parallel-bus interface.
- Captures one RX1+RX2 IQ sample set on each decimator valid strobe.
- Presents the oldest stored set to the bus interface, first-word-fall-through.
- Advances to the next set on each rising edge of the interface's read clock, and reports overrun and underrun to firmware.

Parameters:
- DEPTH, 32: number of stored sample sets; power of two, minimum 4.
- AW, 5: address width, equal to log2(DEPTH).
- IQ_W, 24: width of each signed I/Q component.

Ports:
- clk_in  in  1  system clock, the same clock as the STM32 interface.
- reset_in  in  1  synchronous, active-high reset.
- rx1_i_in  in  IQ_W  RX1 I, signed.
- rx1_q_in  in  IQ_W  RX1 Q, signed.
- rx2_i_in  in  IQ_W  RX2 I, signed.
- rx2_q_in  in  IQ_W  RX2 Q, signed.
- rx_valid  in  1  one-cycle strobe; all four inputs are valid this cycle.
- IQ_RX_READ_REQ  in  1  read request level from the bus interface.
- IQ_RX_READ_CLK  in  1  read strobe from the bus interface; its rising edge pops one set.
- overrun_clr  in  1  one-cycle pulse that clears both sticky flags.
- RX1_I, RX1_Q, RX2_I, RX2_Q  out  IQ_W each  current head sample set, signed.
- iq_overrun  out  1  sticky flag: a write was dropped.
- iq_underrun  out  1  sticky flag: a pop occurred while the buffer was empty.
- empty  out  1  no sample set is presented.
- level  out  AW+1  sets held, counting the presented head, range 0..DEPTH.

Behaviour:
- Reset (synchronous, reset_in=1 at a clk_in edge):
  - Write and read pointers go to 0, level=0, empty=1.
  - All RX outputs go to 0; iq_overrun=0, iq_underrun=0.
  - The internal read_clk_d register goes to 0.
  - Reset takes priority over every concurrent write, pop and clear. A pop or write in progress during reset is discarded.
- Storage word: {rx1_i, rx1_q, rx2_i, rx2_q}, 4*IQ_W = 96 bits.
- Pop event: pop = IQ_RX_READ_CLK & ~read_clk_d & IQ_RX_READ_REQ, where read_clk_d is IQ_RX_READ_CLK registered once.
  - A high level held on IQ_RX_READ_CLK produces exactly one pop.
- FWFT output:
  - The RX outputs always show the head set while level>0, and 0 while level=0.
  - On the clock edge where pop is evaluated, the outputs still show the old head, so the bus interface latches the old head on that edge.
  - The outputs show the next set from the following cycle.
- Write latency: a set written into an empty buffer appears on the outputs and clears empty one cycle after the rx_valid edge.
- Write rules:
  - rx_valid with level<DEPTH: the set is stored and level increments.
  - rx_valid with level=DEPTH and no pop in the same cycle: the set is dropped, iq_overrun=1, level is unchanged.
  - rx_valid with level=DEPTH and a pop in the same cycle: the set is accepted and level stays at DEPTH.
- Pop rules:
  - pop with level>0: the head advances and level decrements.
  - pop with level=0: pointers are unchanged, the outputs stay 0, iq_underrun=1.
  - pop and rx_valid with level=0 in the same cycle: counts as an underrun. The new set is stored, and level becomes 1 on the next cycle.
  - pop and rx_valid with 0<level<DEPTH in the same cycle: both take effect and level is unchanged.
- Pointers are AW bits wide and wrap modulo DEPTH. Full and empty are decided by level only, never by pointer compare.
- Flag clear: overrun_clr clears both flags. If a new overrun or underrun event falls in the same cycle as overrun_clr, the event wins and its flag is set.
- No arithmetic is performed on the samples; they pass through bit-exact, sign preserved.
- Control FSM has two states, derived from level:
  - EMPTY (level=0): moves to HOLD on a write.
  - HOLD (level>0): moves to EMPTY on a pop when level=1 and no write occurs in that cycle.

Decomposition:
- Package rx_iq_pkg holds:
  - IQ_W, and the word width IQ_WORD_W = 4*IQ_W.
  - A typedef for the packed sample-set word, with field offsets.
  - The default DEPTH.
- One sub-module: rx_iq_fifo_ram. It is a simple dual-port DEPTHx96 memory with a synchronous write port and a registered read port addressed with next-head lookahead, so the FWFT output needs no extra bubble.
- The top level holds the pointers, level, pop-edge detection, flags and the output mux.

Test Plan:
1. Reset, then write one set (rx1_i=0x000123, rx1_q=0xFFFF00, rx2_i=0x7FFFFF, rx2_q=0x800000) -> one cycle later the outputs equal these values, empty=0, level=1.
2. Write 3 sets A, B, C, then pulse IQ_RX_READ_CLK high for 1 cycle with REQ=1, three times -> the bus latches A, B, C in order, then empty=1, outputs 0, iq_underrun=0.
3. Hold IQ_RX_READ_CLK high for 5 cycles with 2 sets stored -> exactly one pop; level goes from 2 to 1.
4. Write DEPTH+1 sets with no pops -> level=32, iq_overrun=1, and the 33rd set is absent on later readout. Then pulse overrun_clr -> iq_overrun=0.
5. With level=DEPTH, rx_valid and a pop in the same cycle -> level stays 32, no overrun, and the new set is read last. With level=0, a pop alone -> iq_underrun=1, outputs stay 0.
6. Assert reset_in for one cycle with level=10, concurrent with a pop and a write -> the next cycle shows level=0, empty=1, all outputs 0, both flags 0.
